// File: rtl/pwm_pkg.sv
// pwm_pkg: shared widths, constants and the PWM level compare for the PWM peripheral.
package pwm_pkg;
   localparam int PWM_WIDTH = 8;
   localparam logic [PWM_WIDTH-1:0] DUTY_FULL = 8'hFF;
   localparam int PWM_CHANNELS = 16;
   // 0xFF is special-cased to 100% so the top code is never a one-count low glitch
   function automatic logic pwm_level(input logic [PWM_WIDTH-1:0] cnt, input logic [PWM_WIDTH-1:0] duty);
      return (duty == DUTY_FULL) || (cnt < duty);
   endfunction
endpackage

// File: rtl/pwm_peripheral_if.sv
// pwm_peripheral_if: SPI-written control registers, level signals with no handshake.
interface pwm_peripheral_if;
   import pwm_pkg::*;
   logic [PWM_WIDTH-1:0] en_reg_out_7_0;
   logic [PWM_WIDTH-1:0] en_reg_out_15_8;
   logic [PWM_WIDTH-1:0] en_reg_pwm_7_0;
   logic [PWM_WIDTH-1:0] en_reg_pwm_15_8;
   logic [PWM_WIDTH-1:0] pwm_duty_cycle;
   modport master (output en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle);
   modport slave (input en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle);
endinterface

// File: rtl/pwm_timebase.sv
// pwm_timebase: clock prescaler feeding the free-running 8-bit PWM counter.
module pwm_timebase import pwm_pkg::*; #(
   parameter int PRESCALE = 13
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic                 tick,
   output logic [PWM_WIDTH-1:0] pwm_cnt,
   output logic                 period_last
);
   localparam int PW = $clog2(PRESCALE) + 1;
   logic [PW-1:0] pre_cnt;
   assign tick = pre_cnt == PW'(PRESCALE - 1);
   assign period_last = tick && (pwm_cnt == '1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
         pwm_cnt <= '0;
      end else begin
         pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
         pwm_cnt <= pwm_cnt + PWM_WIDTH'(tick);
      end
   end
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: drives 16 outputs static-low, static-high or from one shared
// double-buffered PWM waveform selected by the SPI control registers.
module pwm_peripheral import pwm_pkg::*; #(
   parameter int PRESCALE = 13
) (
   input  logic                    clk,
   input  logic                    rst_n,
   pwm_peripheral_if.slave         regs,
   output logic [PWM_CHANNELS-1:0] out,
   output logic                    period_start
);
   logic                    tick;
   logic                    period_last;
   logic                    reload;
   logic                    level;
   logic [PWM_WIDTH-1:0]    pwm_cnt;
   logic [PWM_WIDTH-1:0]    duty_active;
   logic [PWM_CHANNELS-1:0] en_out;
   logic [PWM_CHANNELS-1:0] en_pwm;
   pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
      .clk         (clk),
      .rst_n       (rst_n),
      .tick        (tick),
      .pwm_cnt     (pwm_cnt),
      .period_last (period_last)
   );
   assign reload = tick && period_last;
   assign en_out = {regs.en_reg_out_15_8, regs.en_reg_out_7_0};
   assign en_pwm = {regs.en_reg_pwm_15_8, regs.en_reg_pwm_7_0};
   assign level = pwm_level(pwm_cnt, duty_active);
   // duty is shadowed and only reloaded as the counter wraps, keeping each period glitch-free
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         duty_active  <= '0;
         period_start <= 1'b0;
         out          <= '0;
      end else begin
         duty_active  <= reload ? regs.pwm_duty_cycle : duty_active;
         period_start <= reload;
         out          <= en_out & (~en_pwm | {PWM_CHANNELS{level}});
      end
   end
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: scoreboard bench for PRESCALE=13 and PRESCALE=1 builds.
module tb_pwm_peripheral;
   localparam int PA = 13;
   localparam int TA = 256 * PA;
   localparam int TB = 256;
   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_a_n = 1'b0;
   logic        rst_b_n = 1'b0;
   logic [15:0] out_a, out_b;
   logic        ps_a, ps_b;
   int          vectors = 0;
   int          miscompares = 0;
   exp_t        exp_q[$];
   int          cyc, hi, split;
   logic [15:0] andv, orv;
   pwm_peripheral_if ra();
   pwm_peripheral_if rb();
   pwm_peripheral #(.PRESCALE(PA)) dut_a (
      .clk(clk), .rst_n(rst_a_n), .regs(ra), .out(out_a), .period_start(ps_a)
   );
   pwm_peripheral #(.PRESCALE(1)) dut_b (
      .clk(clk), .rst_n(rst_b_n), .regs(rb), .out(out_b), .period_start(ps_b)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic push(input string tag, input logic [31:0] v);
      exp_q.push_back('{tag, v});
   endtask
   task automatic pop_cmp(input logic [31:0] got);
      exp_t e;
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else begin
         e = exp_q.pop_front();
         check(e.tag, got, e.val);
      end
   endtask
   task automatic set_a(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
      {ra.en_reg_out_15_8, ra.en_reg_out_7_0} = eo;
      {ra.en_reg_pwm_15_8, ra.en_reg_pwm_7_0} = ep;
      ra.pwm_duty_cycle = d;
   endtask
   task automatic set_b(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
      {rb.en_reg_out_15_8, rb.en_reg_out_7_0} = eo;
      {rb.en_reg_pwm_15_8, rb.en_reg_pwm_7_0} = ep;
      rb.pwm_duty_cycle = d;
   endtask
   // Samples each negedge until period_start (bounded); optional duty write at cycle chg_at.
   task automatic measure(input bit sel, input int chg_at, input logic [7:0] chg_val);
      int lim;
      logic [15:0] o;
      lim = sel ? TB + 4 : TA + 4;
      cyc = 0; hi = 0; split = 0; andv = '1; orv = '0;
      for (int n = 1; n <= lim; n++) begin
         @(negedge clk);
         if (n == chg_at) begin
            if (sel) rb.pwm_duty_cycle = chg_val;
            else ra.pwm_duty_cycle = chg_val;
         end
         o = sel ? out_b : out_a;
         cyc = n;
         hi += int'(o[0]);
         split += int'(o[7:0] != 8'h00 && o[7:0] != 8'hFF);
         andv &= o;
         orv |= o;
         if (sel ? ps_b : ps_a) break;
      end
   endtask
   initial begin
      set_a(16'h0, 16'h0, 8'h0);
      set_b(16'h0003, 16'h0001, 8'h01);
      repeat (3) @(negedge clk);
      check("rst_out_a", 32'(out_a), 32'h0);
      check("rst_ps_a", 32'(ps_a), 32'h0);
      check("rst_out_b", 32'(out_b), 32'h0);
      rst_b_n = 1'b1;
      push("b_first_cyc", TB); push("b_first_hi", 0); push("b_static_bit1", 1);
      measure(1'b1, 0, 8'h0);
      pop_cmp(cyc); pop_cmp(hi); pop_cmp(32'(andv[1]));
      push("b_duty01_cyc", TB); push("b_duty01_hi", 1);
      measure(1'b1, 0, 8'h0);
      pop_cmp(cyc); pop_cmp(hi);
      repeat (50) @(negedge clk);
      check("b_pre_rst_bit1", 32'(out_b[1]), 32'h1);
      rst_b_n = 1'b0;
      #1;
      check("b_async_rst_out", 32'(out_b), 32'h0);
      check("b_async_rst_ps", 32'(ps_b), 32'h0);
      @(negedge clk);
      rst_b_n = 1'b1;
      push("b_restart_cyc", TB); push("b_restart_hi", 0);
      measure(1'b1, 0, 8'h0);
      pop_cmp(cyc); pop_cmp(hi);
      rst_a_n = 1'b1;
      for (int p = 0; p < 2; p++) begin
         push("idle_cyc", TA); push("idle_or", 0);
         measure(1'b0, 0, 8'h0);
         pop_cmp(cyc); pop_cmp(32'(orv));
      end
      @(negedge clk);
      check("ps_width", 32'(ps_a), 32'h0);
      set_a(16'hFFFF, 16'h0, 8'h0);
      check("en_not_comb", 32'(out_a), 32'h0);
      @(negedge clk);
      check("en_on_1clk", 32'(out_a), 32'hFFFF);
      set_a(16'h0, 16'h0, 8'h0);
      @(negedge clk);
      check("en_off_1clk", 32'(out_a), 32'h0);
      set_a(16'h0FFF, 16'hF0FF, 8'h80);
      measure(1'b0, 0, 8'h0);
      push("d80_cyc", TA); push("d80_hi", 128 * PA); push("d80_split", 0);
      push("static_hi_11_8", 32'hF); push("pwm_no_en_15_12", 0);
      measure(1'b0, 0, 8'h0);
      pop_cmp(cyc); pop_cmp(hi); pop_cmp(split); pop_cmp(32'(andv[11:8])); pop_cmp(32'(orv[15:12]));
      ra.pwm_duty_cycle = 8'h00;
      measure(1'b0, 0, 8'h0);
      push("d00_hi", 0);
      measure(1'b0, 0, 8'h0);
      pop_cmp(hi);
      ra.pwm_duty_cycle = 8'hFF;
      measure(1'b0, 0, 8'h0);
      for (int p = 0; p < 2; p++) begin
         push("dff_hi", TA); push("dff_and_7_0", 32'hFF);
         measure(1'b0, 0, 8'h0);
         pop_cmp(hi); pop_cmp(32'(andv[7:0]));
      end
      ra.pwm_duty_cycle = 8'h40;
      measure(1'b0, 0, 8'h0);
      push("d40_then_c0_cur", 64 * PA);
      measure(1'b0, 100 * PA, 8'hC0);
      pop_cmp(hi);
      push("dc0_next", 192 * PA);
      measure(1'b0, 0, 8'h0);
      pop_cmp(hi);
      check("sb_leftover", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
